// File: rtl/uart_bus_bridge.sv
// Serial debug bridge: 8N1 command frames on rx drive one 32-bit bus read or write; result returns on tx.
// Define UART_BRIDGE_TIMEOUT_EN to abort unanswered bus requests after TIMEOUT_CYCLES and reply 'E'.
module uart_bus_bridge #(
  parameter int CLK_FREQ       = 25000000,
  parameter int BIT_RATE       = 115200,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        read_request,
  output logic        write_request,
  input  logic        read_response,
  input  logic        write_response,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [7:0] CMD_READ      = 8'h52;
  localparam logic [7:0] CMD_WRITE     = 8'h57;
  localparam logic [7:0] REPLY_OK      = 8'h4B;
  localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;
  localparam logic [7:0] REPLY_ERROR   = 8'h45;

  if (CLKS_PER_BIT < 4) begin : g_rate_check
    $error("uart_bus_bridge: CLK_FREQ/BIT_RATE must be at least 4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("uart_bus_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_RD, BUS_WR, RESP} state_e;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;

  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bits_q, tx_bits_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_ready, tx_load;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] resp_buf_q, resp_buf_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic        read_request_q, read_request_d;
  logic        write_request_q, write_request_d;
  logic        bus_done;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Receiver: falling edge, re-check at half a bit, then sample each bit at its centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A new frame may load during the last cycle of the stop bit, keeping bytes back to back.
  assign tx_ready = (tx_bits_q == 4'd0) || (tx_bits_q == 4'd1 && tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_bits_q != 4'd0) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 1'b1;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
    if (tx_load) begin
      tx_shift_d = {1'b1, resp_buf_q[31:24], 1'b0};
      tx_bits_d  = 4'd10;
      tx_cnt_d   = '0;
    end
  end

  assign bus_done = (read_request_q && read_response) || (write_request_q && write_response);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    is_write_d      = is_write_q;
    address_d       = address_q;
    write_data_d    = write_data_q;
    resp_buf_d      = resp_buf_q;
    resp_left_d     = resp_left_q;
    read_request_d  = 1'b0;
    write_request_d = 1'b0;
    tx_load         = 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
    tmo_cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid_q) begin
          cnt_d = '0;
          if (rx_shift_q == CMD_READ || rx_shift_q == CMD_WRITE) begin
            is_write_d = (rx_shift_q == CMD_WRITE);
            state_d    = ADDR;
          end else begin
            resp_buf_d  = {REPLY_UNKNOWN, 24'h0};
            resp_left_d = 3'd1;
            state_d     = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid_q) begin
          address_d = {address_q[23:0], rx_shift_q};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = is_write_q ? WDATA : BUS_RD;
        end
      end
      WDATA: begin
        if (rx_valid_q) begin
          write_data_d = {write_data_q[23:0], rx_shift_q};
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = BUS_WR;
        end
      end
      BUS_RD, BUS_WR: begin
        read_request_d  = (state_q == BUS_RD);
        write_request_d = (state_q == BUS_WR);
        if (read_request_q || write_request_q) begin
          if (bus_done) begin
            read_request_d  = 1'b0;
            write_request_d = 1'b0;
            resp_buf_d      = read_request_q ? read_data : {REPLY_OK, 24'h0};
            resp_left_d     = read_request_q ? 3'd4 : 3'd1;
            state_d         = RESP;
          end
`ifdef UART_BRIDGE_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            read_request_d  = 1'b0;
            write_request_d = 1'b0;
            resp_buf_d      = {REPLY_ERROR, 24'h0};
            resp_left_d     = 3'd1;
            state_d         = RESP;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
`endif
        end
      end
      RESP: begin
        if (resp_left_q == 3'd0) begin
          state_d = IDLE;
        end else if (tx_ready) begin
          tx_load     = 1'b1;
          resp_buf_d  = {resp_buf_q[23:0], 8'h00};
          resp_left_d = resp_left_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_valid_q      <= 1'b0;
      tx_shift_q      <= '1;
      tx_bits_q       <= '0;
      tx_cnt_q        <= '0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      is_write_q      <= 1'b0;
      address_q       <= '0;
      write_data_q    <= '0;
      resp_buf_q      <= '0;
      resp_left_q     <= '0;
      read_request_q  <= 1'b0;
      write_request_q <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      rx_meta_q       <= rx;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_sync_q;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_valid_q      <= rx_valid_d;
      tx_shift_q      <= tx_shift_d;
      tx_bits_q       <= tx_bits_d;
      tx_cnt_q        <= tx_cnt_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      is_write_q      <= is_write_d;
      address_q       <= address_d;
      write_data_q    <= write_data_d;
      resp_buf_q      <= resp_buf_d;
      resp_left_q     <= resp_left_d;
      read_request_q  <= read_request_d;
      write_request_q <= write_request_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
`endif
    end
  end

  assign tx            = tx_shift_q[0];
  assign read_request  = read_request_q;
  assign write_request = write_request_q;
  assign address       = address_q;
  assign write_data    = write_data_q;
endmodule
